slv_guard_rst_ctrl: RTL and testbench

//  Recovery sequencer for the subordinate guard. On a guard reset request it isolates the

---
 rtl/slv_guard_pkg.sv | 34 +++
 rtl/slv_guard_rst_ctrl.sv | 164 ++++++++++++++++
 tb/tb_slv_guard_rst_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slv_guard_pkg.sv
// Shared types and parameter helpers for the subordinate-guard recovery sequencer.
`timescale 1ns/1ps
package slv_guard_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRAIN    = 3'd1,
      ST_RESET    = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_CLEAR    = 3'd4,
      ST_RECOVER  = 3'd5,
      ST_FAIL     = 3'd6
   } rst_ctrl_state_e;

   // A zero-retry configuration still needs a one-bit attempt register.
   function automatic int retry_width(input int maxRetries);
      return (maxRetries > 0) ? $clog2(maxRetries + 1) : 1;
   endfunction

   function automatic bit rst_ctrl_params_ok(input int cntWidth,
                                             input int drainCycles,
                                             input int holdCycles,
                                             input int ackTimeout,
                                             input int maxRetries);
      longint cntMax;
      cntMax = (longint'(1) << cntWidth) - 1;
      return (cntWidth >= 1) && (cntWidth <= 31) &&
             (drainCycles >= 1) && (longint'(drainCycles) <= cntMax) &&
             (holdCycles >= 1) && (longint'(holdCycles) <= cntMax + 1) &&
             (ackTimeout >= 1) && (longint'(ackTimeout) <= cntMax + 1) &&
             (maxRetries >= 0);
   endfunction

endpackage

// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer: isolates the subordinate, drains, pulses its reset with bounded
// retries, then clears the guard's reset request and re-enables pass-through.
`timescale 1ns/1ps
module slv_guard_rst_ctrl
   import slv_guard_pkg::*;
#(
   parameter int CntWidth    = 16,
   parameter int DrainCycles = 256,
   parameter int HoldCycles  = 16,
   parameter int AckTimeout  = 1024,
   parameter int MaxRetries  = 3
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                ctrl_ena_i,
   input  logic                                rst_req_i,
   input  logic                                outstanding_i,
   input  logic                                sub_rst_stat_i,
   input  logic                                clear_fail_i,
   output logic                                guard_ena_o,
   output logic                                isolate_o,
   output logic                                sub_rst_o,
   output logic                                rst_clear_o,
   output logic                                fail_o,
   output logic [2:0]                          state_o,
   output logic [retry_width(MaxRetries)-1:0]  retry_cnt_o
);

   localparam int RetryW = retry_width(MaxRetries);
   localparam logic [CntWidth-1:0] DrainLast = CntWidth'(DrainCycles - 1);
   localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(HoldCycles - 1);
   localparam logic [CntWidth-1:0] AckLast   = CntWidth'(AckTimeout - 1);
   localparam logic [RetryW-1:0]   RetryMax  = RetryW'(MaxRetries);
   localparam bit                  ParamsOk  = rst_ctrl_params_ok(CntWidth, DrainCycles,
                                                                  HoldCycles, AckTimeout,
                                                                  MaxRetries);

   rst_ctrl_state_e     r_state;
   rst_ctrl_state_e     w_nextState;
   logic [CntWidth-1:0] r_cnt;
   logic [RetryW-1:0]   r_retry;
   logic                w_retryInc;
   logic                w_retryClr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_retry <= '0;
      end else begin
         r_state <= w_nextState;
         // The counter restarts on every state change, including a retry back into RESET.
         if (w_nextState != r_state) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CntWidth'(1);
         end
         if (w_retryClr) begin
            r_retry <= '0;
         end else if (w_retryInc) begin
            r_retry <= r_retry + RetryW'(1);
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_retryInc  = 1'b0;
      w_retryClr  = 1'b0;
      // Disabling guarding abandons any episode, but an unrecoverable subordinate stays flagged.
      if (!ctrl_ena_i && (r_state != ST_FAIL)) begin
         w_nextState = ST_IDLE;
         w_retryClr  = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (rst_req_i) begin
                  w_nextState = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!outstanding_i || (r_cnt == DrainLast)) begin
                  w_nextState = ST_RESET;
               end
            end
            ST_RESET: begin
               if (r_cnt == HoldLast) begin
                  w_nextState = ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (sub_rst_stat_i) begin
                  w_nextState = ST_CLEAR;
               end else if (r_cnt == AckLast) begin
                  if (r_retry < RetryMax) begin
                     w_nextState = ST_RESET;
                     w_retryInc  = 1'b1;
                  end else begin
                     w_nextState = ST_FAIL;
                  end
               end
            end
            ST_CLEAR: begin
               w_nextState = ST_RECOVER;
            end
            ST_RECOVER: begin
               // The guard needs a cycle to drop its request after the clear pulse.
               if (!rst_req_i) begin
                  w_nextState = ST_IDLE;
                  w_retryClr  = 1'b1;
               end
            end
            ST_FAIL: begin
               if (clear_fail_i) begin
                  w_nextState = ST_IDLE;
                  w_retryClr  = 1'b1;
               end
            end
            default: begin
               w_nextState = ST_IDLE;
               w_retryClr  = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      guard_ena_o = 1'b0;
      isolate_o   = 1'b0;
      sub_rst_o   = 1'b0;
      rst_clear_o = 1'b0;
      fail_o      = 1'b0;
      state_o     = r_state;
      retry_cnt_o = r_retry;
      case (r_state)
         // Pass-through follows the software enable directly, held off while in reset.
         ST_IDLE:     guard_ena_o = ctrl_ena_i & ~rst_i;
         ST_DRAIN:    isolate_o   = 1'b1;
         ST_RESET: begin
            isolate_o = 1'b1;
            sub_rst_o = 1'b1;
         end
         ST_WAIT_ACK: isolate_o   = 1'b1;
         ST_CLEAR: begin
            isolate_o   = 1'b1;
            rst_clear_o = 1'b1;
         end
         ST_RECOVER:  isolate_o   = 1'b1;
         ST_FAIL: begin
            isolate_o = 1'b1;
            fail_o    = 1'b1;
         end
         default: begin
            isolate_o = 1'b0;
         end
      endcase
   end

   assert property (@(posedge clk_i) ParamsOk);
   assert property (@(posedge clk_i) disable iff (rst_i) rst_clear_o |=> !rst_clear_o);
   assert property (@(posedge clk_i) sub_rst_o |-> (r_state == ST_RESET));
   assert property (@(posedge clk_i) sub_rst_o |-> isolate_o);

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Randomized and directed bench for slv_guard_rst_ctrl against a countdown-based phase model.
`timescale 1ns/1ps
module tb_slv_guard_rst_ctrl;

   localparam int DrainCycles = 256;
   localparam int HoldCycles  = 16;
   localparam int AckTimeout  = 1024;
   localparam int MaxRetries  = 3;

   logic       clk;
   logic       rst;
   logic       ctrlEna;
   logic       rstReq;
   logic       outstanding;
   logic       subRstStat;
   logic       clearFail;
   logic       guardEna;
   logic       isolate;
   logic       subRst;
   logic       rstClear;
   logic       failFlag;
   logic [2:0] stateOut;
   logic [1:0] retryCnt;

   int totalCnt = 0;
   int badCnt   = 0;

   // Phase numbers are the externally visible state codes; mLeft counts cycles still allowed.
   int mPhase    = 0;
   int mLeft     = 0;
   int mAttempts = 0;
   bit mValid    = 1'b0;

   int   subRises  = 0;
   int   clrPulses = 0;
   logic prevSub   = 1'b0;

   slv_guard_rst_ctrl #(
      .CntWidth   (16),
      .DrainCycles(DrainCycles),
      .HoldCycles (HoldCycles),
      .AckTimeout (AckTimeout),
      .MaxRetries (MaxRetries)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ctrl_ena_i    (ctrlEna),
      .rst_req_i     (rstReq),
      .outstanding_i (outstanding),
      .sub_rst_stat_i(subRstStat),
      .clear_fail_i  (clearFail),
      .guard_ena_o   (guardEna),
      .isolate_o     (isolate),
      .sub_rst_o     (subRst),
      .rst_clear_o   (rstClear),
      .fail_o        (failFlag),
      .state_o       (stateOut),
      .retry_cnt_o   (retryCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act !== exp) begin
         badCnt++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit ena, input bit req,
                                input bit outst, input bit stat, input bit clr);
      rst         = r;
      ctrlEna     = ena;
      rstReq      = req;
      outstanding = outst;
      subRstStat  = stat;
      clearFail   = clr;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Reference model: advances once per clock edge from the inputs seen at that edge.
   always @(posedge clk) begin
      if (rst) begin
         mPhase    = 0;
         mLeft     = 0;
         mAttempts = 0;
         mValid    = 1'b1;
      end else if (mValid) begin
         if (!ctrlEna && mPhase != 6) begin
            mPhase    = 0;
            mAttempts = 0;
         end else begin
            case (mPhase)
               0: if (rstReq) begin mPhase = 1; mLeft = DrainCycles; end
               1: begin
                  if (!outstanding || mLeft == 1) begin mPhase = 2; mLeft = HoldCycles; end
                  else mLeft--;
               end
               2: begin
                  if (mLeft == 1) begin mPhase = 3; mLeft = AckTimeout; end
                  else mLeft--;
               end
               3: begin
                  if (subRstStat) mPhase = 4;
                  else if (mLeft == 1) begin
                     if (mAttempts < MaxRetries) begin
                        mAttempts++;
                        mPhase = 2;
                        mLeft  = HoldCycles;
                     end else begin
                        mPhase = 6;
                     end
                  end else mLeft--;
               end
               4: mPhase = 5;
               5: if (!rstReq) begin mPhase = 0; mAttempts = 0; end
               6: if (clearFail) begin mPhase = 0; mAttempts = 0; end
               default: mPhase = 0;
            endcase
         end
      end
   end

   // Every-cycle comparison against the model, plus pulse counters for directed checks.
   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("guard_ena", {31'b0, guardEna}, {31'b0, (mPhase == 0) && ctrlEna && !rst});
         checkOutput("isolate",   {31'b0, isolate},  {31'b0, mPhase != 0});
         checkOutput("sub_rst",   {31'b0, subRst},   {31'b0, mPhase == 2});
         checkOutput("rst_clear", {31'b0, rstClear}, {31'b0, mPhase == 4});
         checkOutput("fail",      {31'b0, failFlag}, {31'b0, mPhase == 6});
         checkOutput("state",     {29'b0, stateOut}, mPhase);
         checkOutput("retry_cnt", {30'b0, retryCnt}, mAttempts);
      end
      if (subRst === 1'b1 && prevSub !== 1'b1) subRises++;
      if (rstClear === 1'b1) clrPulses++;
      prevSub = subRst;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int h;
      int c0;
      int r0;
      int statPct [4] = '{25, 0, 5, 50};

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(2);
      $display("[TB] reset state");
      checkOutput("rst_state",     {29'b0, stateOut}, 0);
      checkOutput("rst_guard_ena", {31'b0, guardEna}, 0);
      checkOutput("rst_isolate",   {31'b0, isolate},  0);
      checkOutput("rst_retry",     {30'b0, retryCnt}, 0);
      rst = 1'b0;
      #1;
      checkOutput("idle_guard_ena", {31'b0, guardEna}, 1);

      $display("[TB] basic recovery");
      rstReq = 1'b1;
      n = 0;
      while (!subRst && n < 10) begin tick(1); n++; end
      checkOutput("req_to_sub_rst_latency", n, 2);
      h = 0;
      while (subRst && h < 100) begin tick(1); h++; end
      checkOutput("sub_rst_hold_cycles", h, 16);
      tick(2);
      subRstStat = 1'b1;
      c0 = clrPulses;
      n = 0;
      while (!rstClear && n < 10) begin tick(1); n++; end
      checkOutput("clear_state", {29'b0, stateOut}, 4);
      subRstStat = 1'b0;
      tick(2);
      checkOutput("recover_held", {29'b0, stateOut}, 5);
      rstReq = 1'b0;
      tick(1);
      checkOutput("back_to_idle", {29'b0, stateOut}, 0);
      tick(1);
      checkOutput("one_clear_pulse", clrPulses - c0, 1);
      checkOutput("idle_guard_after", {31'b0, guardEna}, 1);

      $display("[TB] drain timeout and disable mid reset");
      outstanding = 1'b1;
      rstReq      = 1'b1;
      tick(1);
      n = 0;
      while (stateOut == 3'd1 && n < 400) begin tick(1); n++; end
      checkOutput("drain_cycles", n, 256);
      checkOutput("reset_after_drain", {29'b0, stateOut}, 2);
      tick(5);
      ctrlEna = 1'b0;
      tick(1);
      checkOutput("disable_state",   {29'b0, stateOut}, 0);
      checkOutput("disable_sub_rst", {31'b0, subRst},   0);
      checkOutput("disable_guard",   {31'b0, guardEna}, 0);
      ctrlEna     = 1'b1;
      rstReq      = 1'b0;
      outstanding = 1'b0;
      tick(2);

      $display("[TB] retries exhausted");
      r0     = subRises;
      rstReq = 1'b1;
      n = 0;
      while (!failFlag && n < 6000) begin tick(1); n++; end
      checkOutput("reset_pulses", subRises - r0, 4);
      checkOutput("fail_flag",    {31'b0, failFlag}, 1);
      checkOutput("fail_retry",   {30'b0, retryCnt}, 3);
      ctrlEna = 1'b0;
      tick(3);
      checkOutput("fail_ignores_ena", {29'b0, stateOut}, 6);
      ctrlEna   = 1'b1;
      clearFail = 1'b1;
      tick(1);
      clearFail = 1'b0;
      rstReq    = 1'b0;
      checkOutput("fail_cleared_state", {29'b0, stateOut}, 0);
      checkOutput("fail_cleared_retry", {30'b0, retryCnt}, 0);
      tick(2);

      $display("[TB] ack and timeout coincide");
      rstReq = 1'b1;
      n = 0;
      while (stateOut != 3'd3 && n < 50) begin tick(1); n++; end
      tick(AckTimeout);
      checkOutput("first_timeout_state", {29'b0, stateOut}, 2);
      checkOutput("first_timeout_retry", {30'b0, retryCnt}, 1);
      n = 0;
      while (stateOut != 3'd3 && n < 50) begin tick(1); n++; end
      tick(AckTimeout - 1);
      subRstStat = 1'b1;
      tick(1);
      checkOutput("coincide_state", {29'b0, stateOut}, 4);
      checkOutput("coincide_retry", {30'b0, retryCnt}, 1);
      subRstStat = 1'b0;
      rstReq     = 1'b0;
      tick(2);
      checkOutput("coincide_idle", {29'b0, stateOut}, 0);

      $display("[TB] reset during wait_ack");
      rstReq = 1'b1;
      n = 0;
      while (stateOut != 3'd3 && n < 50) begin tick(1); n++; end
      tick(5);
      rst = 1'b1;
      tick(1);
      checkOutput("wrst_state",   {29'b0, stateOut}, 0);
      checkOutput("wrst_guard",   {31'b0, guardEna}, 0);
      checkOutput("wrst_isolate", {31'b0, isolate},  0);
      checkOutput("wrst_sub_rst", {31'b0, subRst},   0);
      rst    = 1'b0;
      rstReq = 1'b0;
      tick(1);

      $display("[TB] randomized traffic");
      for (int seg = 0; seg < 4; seg++) begin
         for (int cyc = 0; cyc < 5000; cyc++) begin
            tick(1);
            if (seg == 1) begin
               rst     = 1'b0;
               ctrlEna = 1'b1;
            end else begin
               rst     = ($urandom_range(0, 999) == 0);
               ctrlEna = ($urandom_range(0, 63) != 0);
            end
            if (rstReq) rstReq = ($urandom_range(0, 19) != 0);
            else        rstReq = ($urandom_range(0, 9) == 0);
            outstanding = ($urandom_range(0, 3) != 0);
            subRstStat  = ($urandom_range(0, 99) < statPct[seg]);
            clearFail   = ($urandom_range(0, 29) == 0);
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
